// File: rtl/i2c_master.sv
// Single-master I2C engine: START, address, register pointer, then N write bytes or a
// repeated-START read of N bytes, then STOP. Define I2C_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_master #(
  parameter int QDIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       rw,
  input  logic [5:0] N_Byte,
  input  logic [6:0] dev_add,
  input  logic [7:0] R_Pointer,
  input  logic [7:0] dwr,
  output logic [7:0] drd,
  output logic       ready,
  output logic       done,
  output logic       ack_e,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in,
  input  logic       scl_in
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, PTR, ACK2, WDATA, ACK3,
    RSTART, ADDR_R, ACK4, RDATA, MACK, STOP
  } state_t;

  localparam logic [9:0] QMAX = 10'(QDIV - 1);

  state_t      r_state;
  logic [1:0]  r_q;
  logic [9:0]  r_qcnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [5:0]  r_cnt;
  logic        r_rw;
  logic [6:0]  r_dev;
  logic [7:0]  r_ptr;
  logic        r_nack;
  logic        r_scl;
  logic        r_sda_oe;
  logic [7:0]  r_drd;
  logic        r_ready;
  logic        r_done;
  logic        r_ack_e;

  logic w_hold;
  logic w_tick;
  logic w_sample;
  logic w_bit_end;
  logic w_high;
  logic w_scl;
  logic w_sda_oe;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low after we released it freezes the quarter timer.
  assign w_hold = r_scl & ~scl_in;
`else
  logic w_unused_scl_in;
  assign w_unused_scl_in = scl_in;
  assign w_hold = 1'b0;
`endif

  assign w_tick    = (r_state != IDLE) && !w_hold && (r_qcnt == QMAX);
  assign w_sample  = w_tick && (r_q == 2'd1);
  assign w_bit_end = w_tick && (r_q == 2'd3);
  assign w_high    = (r_q == 2'd1) || (r_q == 2'd2);

  always_comb begin
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    case (r_state)
      IDLE: begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
      end
      START: begin
        w_scl    = (r_q != 2'd3);
        w_sda_oe = (r_q != 2'd0);
      end
      RSTART: begin
        w_scl    = w_high;
        w_sda_oe = r_q[1];
      end
      // r_bit=1: the STOP edge itself; r_bit=0: bus-free time with both lines released
      STOP: begin
        w_scl    = (r_bit == 3'd0) || (r_q != 2'd0);
        w_sda_oe = (r_bit != 3'd0) && !r_q[1];
      end
      ADDR, PTR, WDATA, ADDR_R: begin
        w_scl    = w_high;
        w_sda_oe = ~r_shift[7];
      end
      MACK: begin
        w_scl    = w_high;
        w_sda_oe = (r_cnt != 6'd1);
      end
      default: begin
        w_scl    = w_high;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= 2'd0;
      r_qcnt   <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'd0;
      r_cnt    <= 6'd0;
      r_rw     <= 1'b0;
      r_dev    <= 7'd0;
      r_ptr    <= 8'd0;
      r_nack   <= 1'b0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
      r_drd    <= 8'd0;
      r_ready  <= 1'b0;
      r_done   <= 1'b1;
      r_ack_e  <= 1'b0;
    end else begin
      r_scl    <= w_scl;
      r_sda_oe <= w_sda_oe;
      r_ready  <= 1'b0;

      if (r_state == IDLE)
        r_qcnt <= '0;
      else if (!w_hold)
        r_qcnt <= (r_qcnt == QMAX) ? 10'd0 : r_qcnt + 10'd1;

      if (w_tick)
        r_q <= r_q + 2'd1;

      if (r_state == IDLE && go) begin
        r_rw    <= rw;
        r_cnt   <= N_Byte;
        r_dev   <= dev_add;
        r_ptr   <= R_Pointer;
        r_nack  <= 1'b0;
        r_ack_e <= 1'b0;
        r_done  <= 1'b0;
        r_q     <= 2'd0;
        r_state <= START;
      end

      if (w_sample) begin
        case (r_state)
          ACK1, ACK2, ACK3, ACK4: begin
            if (sda_in) begin
              r_nack  <= 1'b1;
              r_ack_e <= 1'b1;
            end
          end
          RDATA:   r_shift <= {r_shift[6:0], sda_in};
          default: ;
        endcase
      end

      if (w_bit_end) begin
        case (r_state)
          START: begin
            r_state <= ADDR;
            r_shift <= {r_dev, 1'b0};
            r_bit   <= 3'd7;
          end
          ADDR, PTR, WDATA, ADDR_R: begin
            if (r_bit != 3'd0) begin
              r_bit   <= r_bit - 3'd1;
              r_shift <= {r_shift[6:0], 1'b0};
            end else begin
              case (r_state)
                ADDR: r_state <= ACK1;
                PTR: begin
                  r_state <= ACK2;
                  r_ready <= !r_rw && (r_cnt != 6'd0);
                end
                WDATA: begin
                  r_state <= ACK3;
                  r_cnt   <= r_cnt - 6'd1;
                  r_ready <= (r_cnt != 6'd1);
                end
                default: r_state <= ACK4;
              endcase
            end
          end
          ACK1: begin
            if (r_nack) begin
              r_state <= STOP;
              r_bit   <= 3'd1;
            end else begin
              r_state <= PTR;
              r_shift <= r_ptr;
              r_bit   <= 3'd7;
            end
          end
          ACK2, ACK3: begin
            if (r_nack || r_cnt == 6'd0) begin
              r_state <= STOP;
              r_bit   <= 3'd1;
            end else if (r_state == ACK2 && r_rw) begin
              r_state <= RSTART;
            end else begin
              r_state <= WDATA;
              r_shift <= dwr;
              r_bit   <= 3'd7;
            end
          end
          RSTART: begin
            r_state <= ADDR_R;
            r_shift <= {r_dev, 1'b1};
            r_bit   <= 3'd7;
          end
          ACK4: begin
            if (r_nack) begin
              r_state <= STOP;
              r_bit   <= 3'd1;
            end else begin
              r_state <= RDATA;
              r_bit   <= 3'd7;
            end
          end
          RDATA: begin
            if (r_bit != 3'd0) begin
              r_bit <= r_bit - 3'd1;
            end else begin
              r_state <= MACK;
              r_drd   <= r_shift;
              r_ready <= 1'b1;
            end
          end
          MACK: begin
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
              r_state <= STOP;
              r_bit   <= 3'd1;
            end else begin
              r_state <= RDATA;
              r_bit   <= 3'd7;
            end
          end
          STOP: begin
            if (r_bit != 3'd0) begin
              r_bit <= 3'd0;
            end else begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign drd    = r_drd;
  assign ready  = r_ready;
  assign done   = r_done;
  assign ack_e  = r_ack_e;
  assign scl    = r_scl;
  assign sda_oe = r_sda_oe;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: a bit-level slave on an open-drain bus, START/STOP and ready monitor.
module tb_i2c_master;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset, go, rw;
  logic [5:0] n_byte;
  logic [6:0] dev;
  logic [7:0] ptr;
  logic [7:0] dwr = 8'h00;
  logic [7:0] drd;
  logic       ready, done, ack_e, scl, sda_oe, sda_in, scl_in;
  logic       slv_drv, stretch, sda_bus;

  assign sda_bus = ~(sda_oe | slv_drv);
  assign sda_in  = sda_bus;
  assign scl_in  = scl & ~stretch;

  i2c_master #(.QDIV(Q)) dut (
    .clk(clk), .reset(reset), .go(go), .rw(rw), .N_Byte(n_byte), .dev_add(dev),
    .R_Pointer(ptr), .dwr(dwr), .drd(drd), .ready(ready), .done(done), .ack_e(ack_e),
    .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in), .scl_in(scl_in)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, starts = 0, stops = 0, rdy_cnt = 0;
  int last_rise = 0;
  logic [7:0] wr_bytes [4];
  logic [7:0] rd_log [4];
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: START/STOP conditions, ready strobes, write data hand-off.
  always @(negedge clk) begin
    if (scl && prev_scl && prev_sda && !sda_bus) starts++;
    if (scl && prev_scl && !prev_sda && sda_bus) stops++;
    prev_scl = scl;
    prev_sda = sda_bus;
    if (ready) begin
      rd_log[rdy_cnt[1:0]] = drd;
      dwr = wr_bytes[rdy_cnt[1:0]];
      rdy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_scl(input logic lvl);
    int n = 0;
    while (scl !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (scl !== lvl) begin
      checks++;
      errors++;
      $error("FAIL scl_timeout observed=%b expected=%b", scl, lvl);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL done_timeout observed=%b expected=1", done);
    end
  endtask

  task automatic clock_bit(input logic drv, output logic smp);
    slv_drv = drv;
    wait_scl(1'b1);
    last_rise = cyc;
    smp = sda_bus;
    wait_scl(1'b0);
    slv_drv = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, input logic ack_drv,
                           output logic [7:0] rx, output logic ack_smp);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(~tx[i], b);
      rx[i] = b;
    end
    clock_bit(ack_drv, ack_smp);
  endtask

  task automatic pulse_go(input logic rw_i, input logic [5:0] n_i,
                          input logic [6:0] dev_i, input logic [7:0] ptr_i);
    rw = rw_i; n_byte = n_i; dev = dev_i; ptr = ptr_i;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    logic a, b;
    logic [2:0] bits;
    int t1, t2, t3, rb, sb, pb;

    reset = 1'b1; go = 1'b0; rw = 1'b0; n_byte = 6'd0; dev = 7'd0; ptr = 8'd0;
    slv_drv = 1'b0; stretch = 1'b0;
    wr_bytes[0] = 8'h60; wr_bytes[1] = 8'hA0; wr_bytes[2] = 8'h00; wr_bytes[3] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ack_e", 32'(ack_e), 32'd0);
    chk("rst_drd", 32'(drd), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Write two bytes; inputs are scrambled after go to prove they were latched.
    rb = rdy_cnt; sb = starts; pb = stops;
    pulse_go(1'b0, 6'd2, 7'h48, 8'h01);
    chk("wr_done_low", 32'(done), 32'd0);
    dev = 7'h00; ptr = 8'hFF; rw = 1'b1; n_byte = 6'd0;
    wait_scl(1'b0);
    chk("wr_start", 32'(starts - sb), 32'd1);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("wr_addr", 32'(rx), 32'h90);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("wr_ptr", 32'(rx), 32'h01);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("wr_d0", 32'(rx), 32'h60);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("wr_d1", 32'(rx), 32'hA0);
    wait_done();
    chk("wr_ready_cnt", 32'(rdy_cnt - rb), 32'd2);
    chk("wr_stop", 32'(stops - pb), 32'd1);
    chk("wr_ack_e", 32'(ack_e), 32'd0);
    $display("txn write dev=48 ptr=01 n=2 ready=%0d stops=%0d ack_e=%b", rdy_cnt - rb, stops - pb, ack_e);

    // Read two bytes through a repeated START.
    rb = rdy_cnt; sb = starts; pb = stops;
    pulse_go(1'b1, 6'd2, 7'h48, 8'h00);
    wait_scl(1'b0);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("rd_addr_w", 32'(rx), 32'h90);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("rd_ptr", 32'(rx), 32'h00);
    clock_bit(1'b0, b);
    chk("rd_rstart_sda_high", 32'(b), 32'd1);
    chk("rd_rstart", 32'(starts - sb), 32'd2);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("rd_addr_r", 32'(rx), 32'h91);
    xfer_byte(8'h19, 1'b0, rx, a);
    chk("rd_byte0_drd", 32'(drd), 32'h19);
    chk("rd_byte0_mack", 32'(a), 32'd0);
    xfer_byte(8'h40, 1'b0, rx, a);
    chk("rd_byte1_nack", 32'(a), 32'd1);
    wait_done();
    chk("rd_log0", 32'(rd_log[2'(rb)]), 32'h19);
    chk("rd_log1", 32'(rd_log[2'(rb + 1)]), 32'h40);
    chk("rd_drd_hold", 32'(drd), 32'h40);
    chk("rd_ready_cnt", 32'(rdy_cnt - rb), 32'd2);
    chk("rd_stop", 32'(stops - pb), 32'd1);
    $display("txn read dev=48 ptr=00 n=2 drd=%02h ready=%0d stops=%0d", drd, rdy_cnt - rb, stops - pb);

    // Address NACK on a write.
    rb = rdy_cnt; pb = stops;
    pulse_go(1'b0, 6'd1, 7'h48, 8'h22);
    wait_scl(1'b0);
    xfer_byte(8'hFF, 1'b0, rx, a);
    chk("nack_addr", 32'(rx), 32'h90);
    wait_done();
    chk("nack_ack_e", 32'(ack_e), 32'd1);
    chk("nack_ready_cnt", 32'(rdy_cnt - rb), 32'd0);
    chk("nack_stop", 32'(stops - pb), 32'd1);
    $display("txn nack dev=48 ack_e=%b ready=%0d stops=%0d", ack_e, rdy_cnt - rb, stops - pb);

    // Pointer-only access: N_Byte=0 with rw=1 must not turn around.
    rb = rdy_cnt; sb = starts; pb = stops;
    pulse_go(1'b1, 6'd0, 7'h48, 8'h5A);
    chk("ptronly_ack_e_clr", 32'(ack_e), 32'd0);
    wait_scl(1'b0);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("ptronly_addr", 32'(rx), 32'h90);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("ptronly_ptr", 32'(rx), 32'h5A);
    wait_done();
    chk("ptronly_starts", 32'(starts - sb), 32'd1);
    chk("ptronly_ready_cnt", 32'(rdy_cnt - rb), 32'd0);
    chk("ptronly_stop", 32'(stops - pb), 32'd1);
    $display("txn ptr-only dev=48 ptr=5A starts=%0d ready=%0d", starts - sb, rdy_cnt - rb);

    // Reset in the middle of the pointer byte; a busy go is ignored.
    sb = starts; pb = stops;
    pulse_go(1'b0, 6'd1, 7'h48, 8'hA5);
    wait_scl(1'b0);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("rst_mid_addr", 32'(rx), 32'h90);
    pulse_go(1'b1, 6'd3, 7'h11, 8'h00);
    chk("busy_go_ignored", 32'(done), 32'd0);
    for (int i = 2; i >= 0; i--) begin
      clock_bit(1'b0, b);
      bits[i] = b;
    end
    chk("rst_mid_ptr_bits", 32'(bits), 32'h5);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_scl", 32'(scl), 32'd1);
    chk("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd1);
    chk("rst_mid_drd", 32'(drd), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_stop", 32'(stops - pb), 32'd0);
    chk("rst_mid_idle", 32'(done & scl), 32'd1);
    chk("rst_mid_starts", 32'(starts - sb), 32'd1);
    $display("txn reset-mid-ptr scl=%b sda_oe=%b done=%b", scl, sda_oe, done);

    // Bit period with the slave holding SCL low for 50 clk after release.
    pb = stops;
    pulse_go(1'b0, 6'd0, 7'h48, 8'h3C);
    wait_scl(1'b0);
    clock_bit(1'b0, b); t1 = last_rise; bits[2] = b;
    wait_scl(1'b1);
    t2 = cyc; bits[1] = sda_bus;
    fork
      begin
        stretch = 1'b1;
        repeat (50) @(posedge clk);
        #1 stretch = 1'b0;
      end
    join_none
    wait_scl(1'b0);
    clock_bit(1'b0, b); t3 = last_rise; bits[0] = b;
    chk("str_addr_bits", 32'(bits), 32'h4);
    for (int i = 4; i >= 0; i--) clock_bit(1'b0, b);
    clock_bit(1'b1, a);
    xfer_byte(8'hFF, 1'b1, rx, a); chk("str_ptr", 32'(rx), 32'h3C);
    wait_done();
    chk("str_period_plain", 32'(t2 - t1), 32'(4 * Q));
`ifdef I2C_CLK_STRETCH_EN
    chk("str_period_stretched", 32'(t3 - t2), 32'(4 * Q + 50));
`else
    chk("str_period_ignored", 32'(t3 - t2), 32'(4 * Q));
`endif
    chk("str_stop", 32'(stops - pb), 32'd1);
    $display("txn stretch periods %0d %0d", t2 - t1, t3 - t2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
